// File: rtl/dsp_pkg.sv
// Shared DSP constants: default datapath widths and FIR scheduler state encoding.
package dsp_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 16;
  localparam int unsigned COEFF_WIDTH_DEF = 16;
  localparam int unsigned FIR_TAPS_DEF    = 8;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd1;
  localparam logic [STATE_W-1:0] ST_MAC   = 3'd2;
  localparam logic [STATE_W-1:0] ST_FLUSH = 3'd3;
  localparam logic [STATE_W-1:0] ST_DUMP  = 3'd4;

endpackage

// File: rtl/fir_mac_scheduler.sv
// Sequences the shared FIR MAC: one sample write, FIR_TAPS tap reads, flush, dump.
// Also arbitrates the single-port coefficient RAM against host writes.
module fir_mac_scheduler
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned COEFF_WIDTH = COEFF_WIDTH_DEF,
  parameter int unsigned FIR_TAPS    = FIR_TAPS_DEF,
  parameter int unsigned ADDR_W      = $clog2(FIR_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fir_start,
  input  logic [DATA_WIDTH-1:0]  adc_data,
  input  logic                   adc_valid,
  input  logic                   coeff_load,
  input  logic [ADDR_W-1:0]      coeff_addr,
  input  logic [COEFF_WIDTH-1:0] coeff_data,
  output logic                   coeff_ready,
  output logic                   smp_wr_en,
  output logic [ADDR_W-1:0]      smp_wr_addr,
  output logic [DATA_WIDTH-1:0]  smp_wr_data,
  output logic [ADDR_W-1:0]      smp_rd_addr,
  output logic                   coef_wr_en,
  output logic [ADDR_W-1:0]      coef_addr,
  output logic [COEFF_WIDTH-1:0] coef_wr_data,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   acc_dump,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(FIR_TAPS - 1);

  logic [STATE_W-1:0]     state, state_nxt;
  logic [ADDR_W-1:0]      tap, tap_nxt;
  logic [ADDR_W-1:0]      wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0]      base, base_nxt;
  logic                   pend_vld, pend_vld_nxt;
  logic [DATA_WIDTH-1:0]  pend_data, pend_data_nxt;
  logic                   overrun_nxt;
  logic                   smp_wr_en_nxt;
  logic [ADDR_W-1:0]      smp_wr_addr_nxt;
  logic [DATA_WIDTH-1:0]  smp_wr_data_nxt;
  logic [ADDR_W-1:0]      smp_rd_addr_nxt;
  logic                   coef_wr_en_nxt;
  logic [ADDR_W-1:0]      coef_addr_nxt;
  logic [COEFF_WIDTH-1:0] coef_wr_data_nxt;
  logic                   mac_clr_nxt, mac_en_nxt, acc_dump_nxt, busy_nxt, coeff_ready_nxt;
  logic                   smp_accept, coef_accept;
  logic                   start_write, take_new;
  logic [DATA_WIDTH-1:0]  write_data;

  assign smp_accept  = adc_valid & fir_start;
  assign coef_accept = coeff_load & coeff_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, pending buffer, address generation and next output values
  always_comb begin
    state_nxt       = state;
    tap_nxt         = tap;
    wr_ptr_nxt      = wr_ptr;
    base_nxt        = base;
    pend_vld_nxt    = pend_vld & fir_start;
    pend_data_nxt   = pend_data;
    overrun_nxt     = overrun;
    smp_wr_en_nxt   = 1'b0;
    smp_wr_addr_nxt = '0;
    smp_wr_data_nxt = '0;
    smp_rd_addr_nxt = '0;
    start_write     = 1'b0;
    take_new        = 1'b0;
    write_data      = adc_data;

    case (state)
      ST_IDLE: begin
        if (smp_accept) begin
          start_write = 1'b1;
          take_new    = 1'b1;
        end
      end
      ST_WRITE: begin
        state_nxt       = ST_MAC;
        tap_nxt         = '0;
        smp_rd_addr_nxt = base;
      end
      ST_MAC: begin
        if (tap == LAST_TAP) begin
          state_nxt = ST_FLUSH;
        end else begin
          tap_nxt         = tap + ADDR_W'(1);
          smp_rd_addr_nxt = base - tap - ADDR_W'(1);
        end
      end
      ST_FLUSH: state_nxt = ST_DUMP;
      ST_DUMP: begin
        state_nxt = ST_IDLE;
        if (pend_vld & fir_start) begin
          start_write  = 1'b1;
          write_data   = pend_data;
          pend_vld_nxt = 1'b0;
        end else if (smp_accept) begin
          // Empty pending buffer: the DUMP-cycle sample goes straight to WRITE
          start_write = 1'b1;
          take_new    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (smp_accept && !take_new) begin
      if (pend_vld) begin
        overrun_nxt = 1'b1;
      end else begin
        pend_vld_nxt  = 1'b1;
        pend_data_nxt = adc_data;
      end
    end

    if (start_write) begin
      state_nxt       = ST_WRITE;
      smp_wr_en_nxt   = 1'b1;
      smp_wr_addr_nxt = wr_ptr;
      smp_wr_data_nxt = write_data;
      base_nxt        = wr_ptr;
      wr_ptr_nxt      = wr_ptr + ADDR_W'(1);
    end

    // A landing host write owns the shared coefficient port
    coef_wr_en_nxt   = coef_accept;
    coef_wr_data_nxt = coef_accept ? coeff_data : '0;
    if (coef_accept)              coef_addr_nxt = coeff_addr;
    else if (state_nxt == ST_MAC) coef_addr_nxt = tap_nxt;
    else                          coef_addr_nxt = '0;

    // MAC strobes trail the tap reads by the one-cycle RAM latency
    mac_en_nxt      = (state == ST_MAC);
    mac_clr_nxt     = (state == ST_MAC) && (tap == '0);
    acc_dump_nxt    = (state_nxt == ST_DUMP);
    busy_nxt        = (state_nxt != ST_IDLE);
    coeff_ready_nxt = (state_nxt != ST_MAC);
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap          <= '0;
      wr_ptr       <= '0;
      base         <= '0;
      pend_vld     <= 1'b0;
      pend_data    <= '0;
      overrun      <= 1'b0;
      smp_wr_en    <= 1'b0;
      smp_wr_addr  <= '0;
      smp_wr_data  <= '0;
      smp_rd_addr  <= '0;
      coef_wr_en   <= 1'b0;
      coef_addr    <= '0;
      coef_wr_data <= '0;
      mac_clr      <= 1'b0;
      mac_en       <= 1'b0;
      acc_dump     <= 1'b0;
      busy         <= 1'b0;
      coeff_ready  <= 1'b0;
    end else begin
      tap          <= tap_nxt;
      wr_ptr       <= wr_ptr_nxt;
      base         <= base_nxt;
      pend_vld     <= pend_vld_nxt;
      pend_data    <= pend_data_nxt;
      overrun      <= overrun_nxt;
      smp_wr_en    <= smp_wr_en_nxt;
      smp_wr_addr  <= smp_wr_addr_nxt;
      smp_wr_data  <= smp_wr_data_nxt;
      smp_rd_addr  <= smp_rd_addr_nxt;
      coef_wr_en   <= coef_wr_en_nxt;
      coef_addr    <= coef_addr_nxt;
      coef_wr_data <= coef_wr_data_nxt;
      mac_clr      <= mac_clr_nxt;
      mac_en       <= mac_en_nxt;
      acc_dump     <= acc_dump_nxt;
      busy         <= busy_nxt;
      coeff_ready  <= coeff_ready_nxt;
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench: cycle-schedule model of the scheduler plus literal spot checks.
module tb_fir_mac_scheduler;

  localparam int N  = 8;
  localparam int NC = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fir_start;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        coeff_load;
  logic [2:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic        coeff_ready;
  logic        smp_wr_en;
  logic [2:0]  smp_wr_addr;
  logic [15:0] smp_wr_data;
  logic [2:0]  smp_rd_addr;
  logic        coef_wr_en;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wr_data;
  logic        mac_clr, mac_en, acc_dump, busy, overrun;

  fir_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n), .fir_start(fir_start), .adc_data(adc_data),
    .adc_valid(adc_valid), .coeff_load(coeff_load), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .coeff_ready(coeff_ready), .smp_wr_en(smp_wr_en),
    .smp_wr_addr(smp_wr_addr), .smp_wr_data(smp_wr_data), .smp_rd_addr(smp_rd_addr),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wr_data(coef_wr_data),
    .mac_clr(mac_clr), .mac_en(mac_en), .acc_dump(acc_dump), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected schedule, indexed by cycle number
  bit e_wr_en [NC]; int e_wr_addr [NC]; int e_wr_data [NC];
  bit e_rd [NC];    int e_rd_addr [NC]; int e_k [NC];
  bit e_mac [NC];   bit e_en [NC];      bit e_clr [NC];
  bit e_dump [NC];  bit e_busy [NC];
  bit e_cfw [NC];   int e_cfa [NC];     int e_cfd [NC];
  bit rst_mark [NC];
  int m_wp; bit m_pend; int m_pend_d; bit m_ovr;

  // DUT history for literal checks
  bit lg_wr_en [NC]; int lg_wr_addr [NC]; int lg_rd [NC];
  bit lg_cfw [NC];   int lg_cfa [NC];     int lg_cfd [NC];
  bit lg_dump [NC];  bit lg_en [NC];      bit lg_clr [NC];
  bit lg_ready [NC]; bit lg_ovr [NC];     bit lg_busy [NC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One sample write at cycle w occupies w .. w+N+2
  task automatic schedule(input int w, input int d);
    e_wr_en[w] = 1'b1; e_wr_addr[w] = m_wp; e_wr_data[w] = d;
    for (int k = 0; k < N; k++) begin
      e_rd[w+1+k] = 1'b1; e_rd_addr[w+1+k] = (m_wp - k) & (N - 1);
      e_k[w+1+k] = k; e_mac[w+1+k] = 1'b1; e_en[w+2+k] = 1'b1;
    end
    e_clr[w+2] = 1'b1;
    e_dump[w+N+2] = 1'b1;
    for (int i = w; i <= w + N + 2; i++) e_busy[i] = 1'b1;
    m_wp = (m_wp + 1) % N;
  endtask

  // Model: consume the inputs of the cycle ending at this edge
  always @(posedge clk) begin : model
    int cur, nxt;
    bit full;
    cur = cyc;
    nxt = cyc + 1;
    if (nxt + N + 4 >= NC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", nxt, NC);
      $fatal(1);
    end
    if (!rst_n) begin
      for (int i = nxt; i < NC; i++) begin
        e_wr_en[i] = 0; e_rd[i] = 0; e_mac[i] = 0; e_en[i] = 0; e_clr[i] = 0;
        e_dump[i] = 0; e_busy[i] = 0; e_cfw[i] = 0; rst_mark[i] = 0;
      end
      rst_mark[nxt] = 1'b1;
      m_wp = 0; m_pend = 0; m_ovr = 0;
    end else begin
      if (coeff_load && !e_mac[cur] && !rst_mark[cur]) begin
        e_cfw[nxt] = 1'b1; e_cfa[nxt] = int'(coeff_addr); e_cfd[nxt] = int'(coeff_data);
      end
      if (!fir_start) m_pend = 0;
      full = m_pend;
      if (e_dump[cur] && full) begin
        schedule(nxt, m_pend_d);
        m_pend = 0;
      end
      if (adc_valid && fir_start) begin
        if (!e_busy[cur])               schedule(nxt, int'(adc_data));
        else if (e_dump[cur] && !full)  schedule(nxt, int'(adc_data));
        else if (!full) begin m_pend = 1; m_pend_d = int'(adc_data); end
        else                            m_ovr = 1;
      end
    end
    cyc = nxt;
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin : cmp
    int c;
    c = cyc;
    lg_wr_en[c] = smp_wr_en; lg_wr_addr[c] = int'(smp_wr_addr); lg_rd[c] = int'(smp_rd_addr);
    lg_cfw[c] = coef_wr_en; lg_cfa[c] = int'(coef_addr); lg_cfd[c] = int'(coef_wr_data);
    lg_dump[c] = acc_dump; lg_en[c] = mac_en; lg_clr[c] = mac_clr;
    lg_ready[c] = coeff_ready; lg_ovr[c] = overrun; lg_busy[c] = busy;
    if (!rst_n || rst_mark[c]) begin
      chk("rst_ctrl", {24'd0, busy, mac_en, mac_clr, acc_dump, smp_wr_en, coef_wr_en, coeff_ready, overrun}, 32'd0);
      chk("rst_addr", {23'd0, smp_wr_addr, smp_rd_addr, coef_addr}, 32'd0);
      chk("rst_data", {smp_wr_data, coef_wr_data}, 32'd0);
    end else begin
      chk("busy", busy, e_busy[c]);
      chk("mac_en", mac_en, e_en[c]);
      chk("mac_clr", mac_clr, e_clr[c]);
      chk("acc_dump", acc_dump, e_dump[c]);
      chk("smp_wr_en", smp_wr_en, e_wr_en[c]);
      chk("coef_wr_en", coef_wr_en, e_cfw[c]);
      chk("coeff_ready", coeff_ready, !e_mac[c]);
      chk("overrun", overrun, m_ovr);
      if (e_wr_en[c]) begin
        chk("smp_wr_addr", smp_wr_addr, e_wr_addr[c]);
        chk("smp_wr_data", smp_wr_data, e_wr_data[c]);
      end
      if (e_rd[c]) chk("smp_rd_addr", smp_rd_addr, e_rd_addr[c]);
      if (e_cfw[c]) begin
        chk("coef_addr_wr", coef_addr, e_cfa[c]);
        chk("coef_wr_data", coef_wr_data, e_cfd[c]);
      end else if (e_rd[c]) begin
        chk("coef_addr_rd", coef_addr, e_k[c]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  function automatic int count_dump(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(lg_dump[i]);
    return n;
  endfunction

  initial begin : stim
    int t, t2, n;
    bit got;
    int exp_rd [8];
    exp_rd = '{1, 0, 7, 6, 5, 4, 3, 2};
    rst_n = 1'b0; fir_start = 1'b0; adc_valid = 1'b0; adc_data = '0;
    coeff_load = 1'b0; coeff_addr = '0; coeff_data = '0;
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    rst_n = 1'b1; fir_start = 1'b1;
    repeat (2) tick();

    // First sample: latency pins
    t = cyc;
    send(16'h0011);
    repeat (12) tick();
    chk("t1_wr_en", lg_wr_en[t+1], 1'b1);
    chk("t1_wr_addr", lg_wr_addr[t+1], 0);
    chk("t1_clr", lg_clr[t+3], 1'b1);
    chk("t1_en_first", lg_en[t+3], 1'b1);
    chk("t1_en_last", lg_en[t+10], 1'b1);
    n = 0;
    for (int i = t; i <= t + 12; i++) n += int'(lg_en[i]);
    chk("t1_en_count", n, N);
    chk("t1_dump_at", lg_dump[t+11], 1'b1);
    chk("t1_dump_count", count_dump(t, t + 12), 1);

    // Second sample: base 1 read order
    t = cyc;
    send(16'h0022);
    repeat (12) tick();
    for (int k = 0; k < N; k++) begin
      chk("t2_rd_addr", lg_rd[t+2+k], exp_rd[k]);
      chk("t2_coef_addr", lg_cfa[t+2+k], k);
    end

    // Samples 3..9: ninth wraps to address 0
    for (int s = 3; s <= 9; s++) begin
      t = cyc;
      send(16'(s));
      repeat (12) tick();
    end
    chk("t3_wrap_wr_en", lg_wr_en[t+1], 1'b1);
    chk("t3_wrap_addr", lg_wr_addr[t+1], 0);
    chk("t3_wrap_dump", lg_dump[t+11], 1'b1);

    // Three back-to-back samples: pending then overrun
    t = cyc;
    send(16'h00a1); send(16'h00a2); send(16'h00a3);
    repeat (28) tick();
    chk("t4_ovr_before", lg_ovr[t+2], 1'b0);
    chk("t4_ovr_after", lg_ovr[t+3], 1'b1);
    chk("t4_second_write", lg_wr_en[t+12], 1'b1);
    chk("t4_second_addr", lg_wr_addr[t+12], 2);
    chk("t4_dump_count", count_dump(t, t + 30), 2);

    // Coefficient write stalled through MAC
    t = cyc;
    send(16'h0055);
    tick();
    coeff_load = 1'b1; coeff_addr = 3'd3; coeff_data = 16'h1000;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (coeff_ready) got = 1'b1;
      tick();
    end
    coeff_load = 1'b0;
    chk("t5_accept_in_time", got, 1'b1);
    repeat (3) tick();
    n = 0;
    for (int i = t + 2; i <= t + 9; i++) n += int'(!lg_ready[i]);
    chk("t5_not_ready_count", n, N);
    chk("t5_ready_flush", lg_ready[t+10], 1'b1);
    chk("t5_cfw_dump", lg_cfw[t+11], 1'b1);
    chk("t5_cfa", lg_cfa[t+11], 3);
    chk("t5_cfd", lg_cfd[t+11], 32'h1000);
    chk("t5_dump", lg_dump[t+11], 1'b1);

    // Reset mid-MAC
    t = cyc;
    send(16'h0066);
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("t6_busy_before", lg_busy[t+4], 1'b1);
    chk("t6_busy_reset", lg_busy[t+5], 1'b0);
    chk("t6_ovr_reset", lg_ovr[t+5], 1'b0);
    chk("t6_no_dump", count_dump(t, t + 18), 0);
    t2 = cyc;
    send(16'h0067);
    repeat (12) tick();
    chk("t6_wr_en", lg_wr_en[t2+1], 1'b1);
    chk("t6_wr_addr", lg_wr_addr[t2+1], 0);

    // fir_start dropped with pending full
    t = cyc;
    send(16'h0071); send(16'h0072);
    repeat (3) tick();
    fir_start = 1'b0;
    send(16'h0077);
    repeat (14) tick();
    chk("t7_dump", lg_dump[t+11], 1'b1);
    chk("t7_no_second_write", lg_wr_en[t+12], 1'b0);
    chk("t7_idle", lg_busy[t+12], 1'b0);
    chk("t7_ovr", lg_ovr[t+19], 1'b0);
    chk("t7_dump_count", count_dump(t, t + 19), 1);

    // Simultaneous sample and coefficient accept in IDLE
    fir_start = 1'b1;
    t = cyc;
    coeff_load = 1'b1; coeff_addr = 3'd5; coeff_data = 16'habcd;
    send(16'h0088);
    coeff_load = 1'b0;
    repeat (12) tick();
    chk("t8_wr_en", lg_wr_en[t+1], 1'b1);
    chk("t8_wr_addr", lg_wr_addr[t+1], 2);
    chk("t8_cfw", lg_cfw[t+1], 1'b1);
    chk("t8_cfa", lg_cfa[t+1], 5);
    chk("t8_dump", lg_dump[t+11], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
